// File: rtl/fir_pkg.sv
// Shared definitions for the time-multiplexed FIR tap sequencer:
// sequencer state encoding, default parameter values and result width derivation.
package fir_pkg;

    // Sequencer states: waiting for a sample, or stepping the MAC across the taps.
    typedef enum logic {
        IDLE = 1'b0,
        MAC  = 1'b1
    } fir_state_e;

    localparam int DEF_NUM_OF_TAPS = 3;
    localparam int DEF_INPUT_WIDTH = 8;
    localparam int DEF_COEF_WIDTH  = 8;

    // Result width wide enough that a full sum of N unsigned products cannot wrap.
    function automatic int calc_output_width(input int input_width,
                                             input int coef_width,
                                             input int num_of_taps);
        return input_width + coef_width + $clog2(num_of_taps);
    endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Coefficient register file. Writes are accepted only while the sequencer allows
// them and the address names a real tap; any other write strobe produces a
// one-cycle error pulse. The read port is combinational, indexed by tap number.
module fir_coef_bank
    import fir_pkg::*;
#(
    parameter int NUM_OF_TAPS = DEF_NUM_OF_TAPS,
    parameter int COEF_WIDTH  = DEF_COEF_WIDTH,
    parameter int ADDR_WIDTH  = $clog2(DEF_NUM_OF_TAPS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_allow,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [COEF_WIDTH-1:0] wr_data,
    output logic                  wr_err,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [COEF_WIDTH-1:0] rd_data
);

    logic [COEF_WIDTH-1:0] coef_q [NUM_OF_TAPS];
    logic [COEF_WIDTH-1:0] coef_d [NUM_OF_TAPS];
    logic                  wr_err_q;
    logic                  wr_err_d;
    logic                  addr_ok;
    logic                  wr_ok;

    // Write validation and next-state of the coefficient registers.
    always_comb begin
        addr_ok  = (32'(wr_addr) < NUM_OF_TAPS);
        wr_ok    = wr_en & wr_allow & addr_ok;
        wr_err_d = wr_en & ~wr_ok;
        for (int i = 0; i < NUM_OF_TAPS; i++) begin
            coef_d[i] = coef_q[i];
            if (wr_ok && (wr_addr == ADDR_WIDTH'(i))) begin
                coef_d[i] = wr_data;
            end
        end
    end

    // Combinational read of the coefficient for the current tap.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_OF_TAPS; i++) begin
            if (rd_addr == ADDR_WIDTH'(i)) begin
                rd_data = coef_q[i];
            end
        end
    end

    // Coefficient storage and registered error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_OF_TAPS; i++) begin
                coef_q[i] <= '0;
            end
            wr_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_OF_TAPS; i++) begin
                coef_q[i] <= coef_d[i];
            end
            wr_err_q <= wr_err_d;
        end
    end

    assign wr_err = wr_err_q;

endmodule

// File: rtl/fir_tap_sequencer.sv
// Time-multiplexed FIR: one multiplier-accumulator is stepped across all taps,
// one tap per clock. Holds the tap delay line, a one-entry pending sample buffer
// and the sequencer FSM; coefficients live in fir_coef_bank.
//
// Sample interface: input_data is taken on any edge where input_data_flag is high.
// It is either accepted (IDLE, nothing pending), parked in the pending buffer, or
// dropped with an overflow pulse when the buffer is already occupied. There is no
// back-pressure; busy only reports that a MAC sequence is running.
module fir_tap_sequencer
    import fir_pkg::*;
#(
    parameter int NUM_OF_TAPS  = DEF_NUM_OF_TAPS,
    parameter int INPUT_WIDTH  = DEF_INPUT_WIDTH,
    parameter int COEF_WIDTH   = DEF_COEF_WIDTH,
    parameter int OUTPUT_WIDTH = calc_output_width(DEF_INPUT_WIDTH, DEF_COEF_WIDTH, DEF_NUM_OF_TAPS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [INPUT_WIDTH-1:0]         input_data,
    input  logic                           input_data_flag,
    input  logic                           coef_wr_en,
    input  logic [$clog2(NUM_OF_TAPS)-1:0] coef_addr,
    input  logic [COEF_WIDTH-1:0]          coef_data,
    output logic                           coef_wr_err,
    output logic                           busy,
    output logic [OUTPUT_WIDTH-1:0]        output_data,
    output logic                           output_data_flag,
    output logic                           overflow
);

    localparam int ADDR_WIDTH = $clog2(NUM_OF_TAPS);

    fir_state_e              state_q, state_d;
    logic [ADDR_WIDTH-1:0]   k_q, k_d;
    logic [OUTPUT_WIDTH-1:0] acc_q, acc_d;
    logic [INPUT_WIDTH-1:0]  taps_q [NUM_OF_TAPS];
    logic [INPUT_WIDTH-1:0]  taps_d [NUM_OF_TAPS];
    logic                    pend_valid_q, pend_valid_d;
    logic [INPUT_WIDTH-1:0]  pend_data_q, pend_data_d;
    logic [OUTPUT_WIDTH-1:0] out_data_q, out_data_d;
    logic                    out_flag_q, out_flag_d;
    logic                    overflow_q, overflow_d;

    logic                    accept;
    logic [INPUT_WIDTH-1:0]  accept_sample;
    logic [INPUT_WIDTH-1:0]  tap_sel;
    logic [COEF_WIDTH-1:0]   coef_sel;
    logic [OUTPUT_WIDTH-1:0] product;
    logic                    last_tap;

    fir_coef_bank #(
        .NUM_OF_TAPS (NUM_OF_TAPS),
        .COEF_WIDTH  (COEF_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) u_coef_bank (
        .clk      (clk),
        .rst      (rst),
        .wr_allow (state_q == IDLE),
        .wr_en    (coef_wr_en),
        .wr_addr  (coef_addr),
        .wr_data  (coef_data),
        .wr_err   (coef_wr_err),
        .rd_addr  (k_q),
        .rd_data  (coef_sel)
    );

    // Current tap product; the result width guarantees the multiply cannot wrap.
    always_comb begin
        tap_sel = '0;
        for (int i = 0; i < NUM_OF_TAPS; i++) begin
            if (k_q == ADDR_WIDTH'(i)) begin
                tap_sel = taps_q[i];
            end
        end
        product  = OUTPUT_WIDTH'(tap_sel) * OUTPUT_WIDTH'(coef_sel);
        last_tap = (k_q == ADDR_WIDTH'(NUM_OF_TAPS - 1));
    end

    // Sequencer next state: accept/pending/drop decisions and MAC stepping.
    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        acc_d         = acc_q;
        pend_valid_d  = pend_valid_q;
        pend_data_d   = pend_data_q;
        out_data_d    = out_data_q;
        out_flag_d    = 1'b0;
        overflow_d    = 1'b0;
        accept        = 1'b0;
        accept_sample = '0;
        for (int i = 0; i < NUM_OF_TAPS; i++) begin
            taps_d[i] = taps_q[i];
        end

        case (state_q)
            IDLE: begin
                if (pend_valid_q) begin
                    // The parked sample goes first; a sample arriving now takes its slot.
                    accept        = 1'b1;
                    accept_sample = pend_data_q;
                    pend_valid_d  = input_data_flag;
                    if (input_data_flag) begin
                        pend_data_d = input_data;
                    end
                end else if (input_data_flag) begin
                    accept        = 1'b1;
                    accept_sample = input_data;
                end
            end
            MAC: begin
                if (input_data_flag) begin
                    if (pend_valid_q) begin
                        overflow_d = 1'b1;
                    end else begin
                        pend_valid_d = 1'b1;
                        pend_data_d  = input_data;
                    end
                end
                acc_d = acc_q + product;
                if (last_tap) begin
                    out_data_d = acc_q + product;
                    out_flag_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            taps_d[0] = accept_sample;
            for (int i = 1; i < NUM_OF_TAPS; i++) begin
                taps_d[i] = taps_q[i-1];
            end
            acc_d   = '0;
            k_d     = '0;
            state_d = MAC;
        end
    end

    // FSM, delay line, pending buffer and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            k_q          <= '0;
            acc_q        <= '0;
            pend_valid_q <= 1'b0;
            pend_data_q  <= '0;
            out_data_q   <= '0;
            out_flag_q   <= 1'b0;
            overflow_q   <= 1'b0;
            for (int i = 0; i < NUM_OF_TAPS; i++) begin
                taps_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            acc_q        <= acc_d;
            pend_valid_q <= pend_valid_d;
            pend_data_q  <= pend_data_d;
            out_data_q   <= out_data_d;
            out_flag_q   <= out_flag_d;
            overflow_q   <= overflow_d;
            for (int i = 0; i < NUM_OF_TAPS; i++) begin
                taps_q[i] <= taps_d[i];
            end
        end
    end

    assign busy             = (state_q == MAC);
    assign output_data      = out_data_q;
    assign output_data_flag = out_flag_q;
    assign overflow         = overflow_q;

endmodule

// File: doc/fir_tap_sequencer.md
# fir_tap_sequencer

Time-multiplexed controller for the FIR datapath: accepts samples on the `input_data` / `input_data_flag` interface, maintains the tap delay line, and sequences a single multiplier-accumulator across all `NUM_OF_TAPS` taps, one tap per clock. It also owns the coefficient register bank and its runtime write port. It sits in front of `fir_filter` consumers and replaces the fully parallel tap array where area matters more than throughput.

## Interface
- `NUM_OF_TAPS`, 3: number of taps and coefficients, ≥2.
- `INPUT_WIDTH`, 8: sample width, unsigned.
- `COEF_WIDTH`, 8: coefficient width, unsigned.
- `OUTPUT_WIDTH`, INPUT_WIDTH+COEF_WIDTH+$clog2(NUM_OF_TAPS): accumulator and result width.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `input_data`  in  INPUT_WIDTH  sample.
- `input_data_flag`  in  1  sample valid, one-cycle qualifier.
- `coef_wr_en`  in  1  coefficient write strobe.
- `coef_addr`  in  $clog2(NUM_OF_TAPS)  tap index.
- `coef_data`  in  COEF_WIDTH  coefficient value.
- `coef_wr_err`  out  1  pulse: write rejected (busy or address ≥ NUM_OF_TAPS).
- `busy`  out  1  MAC sequence in progress.
- `output_data`  out  OUTPUT_WIDTH  filtered result, held until next result.
- `output_data_flag`  out  1  one-cycle pulse, `output_data` valid.
- `overflow`  out  1  pulse: sample dropped.

## Operation
- Reset: all outputs 0, delay line 0, coefficients 0, pending buffer empty, state IDLE.
- States: IDLE, MAC.
- IDLE: if pending valid, accept pending; else if `input_data_flag`, accept `input_data`. Accept edge: delay line shifts (tap[0] <= sample, tap[k] <= tap[k-1]), acc <= 0, tap counter k <= 0, → MAC.
- MAC: each edge acc += tap[k]*coef[k], k++. At edge with k = NUM_OF_TAPS-1: `output_data` <= acc + tap[k]*coef[k], `output_data_flag` <= 1, → IDLE.
- `busy` = (state == MAC).
- Pending buffer (one entry): a flagged sample arriving while in MAC, or in IDLE while pending is consumed, is stored in pending. If pending is already full, the new sample is dropped and `overflow` pulses; the stored pending sample is kept.
- Coefficient write: accepted only in IDLE with valid address, takes effect next edge. Otherwise ignored and `coef_wr_err` pulses the following cycle. A write in IDLE on the same edge as an accept is accepted; the new coefficient is used by that sequence.
- Arithmetic: unsigned, no saturation; OUTPUT_WIDTH guarantees no overflow.
- Reset mid-sequence: aborts immediately, no flag pulse, pending cleared.

## Timing
- Accept edge E0; MAC edges E1..EN (N = NUM_OF_TAPS); `output_data_flag` high for the cycle after EN. Latency is N edges from accept.
- Maximum sustained rate: one sample per N+1 cycles. A back-to-back pending sample is accepted on the first IDLE edge after EN.
- `overflow` and `coef_wr_err` are registered, one cycle wide.

## Structure
- Shared package `fir_pkg`: state enum (IDLE, MAC), `OUTPUT_WIDTH` derivation function, default parameter constants.
- Sub-module `fir_coef_bank`: coefficient register file with write validation and combinational read by tap index.
- Sequencer FSM, delay line, pending buffer and MAC live in the top module.

## Test plan
- Reset then sample 17 with coefficients 0 → `output_data_flag` 3 cycles after accept, `output_data` = 0.
- Write coefficients {1,2,3} in IDLE; samples 17, then 18, then 19, spaced 10 cycles → outputs 17, 52, 106.
- Sample 18 flagged one cycle after 17 was accepted → held in pending, accepted at first IDLE edge; both results 17 and 52 appear, no `overflow`.
- Three samples on consecutive cycles (N=3) → third dropped, `overflow` pulses once, two results produced.
- `coef_wr_en` during MAC, and a write with addr=3 in IDLE → `coef_wr_err` pulses, coefficients unchanged, output unaffected.
- Assert `rst` at E2 of a sequence → no `output_data_flag`, all outputs 0, and the next sample behaves as it does after a fresh reset.
